instr_encoder_loader: RTL and testbench

Producer end of the control decoder's instruction format: takes symbolic instructions (mnemonic ID plus register/immediate fields) over a valid/ready stream and packs them into 32-bit words in the exact opcode layout the control decoder consumes. It streams the packed words into instruction memory through a write handshake, auto-incrementing the address. It is used by the bench and boot path to load programs before the core is released from reset.

---
 rtl/instr_pkg.sv | 77 +++++++
 rtl/skid_fifo2.sv | 76 +++++++
 rtl/instr_encoder_loader.sv | 152 +++++++++++++++
 tb/tb_instr_encoder_loader.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared instruction-format definitions for the encoder/loader and the
// control decoder: opcode constants, mnemonic IDs, loader FSM states and the
// symbolic-to-binary encode function.
package instr_pkg;

  // 6-bit primary opcodes, bits [31:26] of every instruction word
  localparam logic [5:0] OP_AND  = 6'b100000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_JR   = 6'b001000;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_NOR  = 6'b100110;
  localparam logic [5:0] OP_NORI = 6'b001110;
  localparam logic [5:0] OP_NOT  = 6'b000100;
  localparam logic [5:0] OP_BLEU = 6'b010000;
  localparam logic [5:0] OP_ROLV = 6'b000000;
  localparam logic [5:0] OP_RORV = 6'b000010;

  // Mnemonic IDs carried on the symbolic stream; 11..15 are illegal
  typedef enum logic [3:0] {
    MN_AND  = 4'd0,
    MN_LW   = 4'd1,
    MN_SW   = 4'd2,
    MN_JR   = 4'd3,
    MN_JAL  = 4'd4,
    MN_NOR  = 4'd5,
    MN_NORI = 4'd6,
    MN_NOT  = 4'd7,
    MN_BLEU = 4'd8,
    MN_ROLV = 4'd9,
    MN_RORV = 4'd10
  } mnem_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } load_state_e;

  typedef struct packed {
    logic [31:0] word;
    logic        legal;
  } enc_t;

  // Pack a symbolic instruction into its 32-bit word; legal=0 for unknown IDs
  function automatic enc_t encode(input logic [3:0]  mnem,
                                  input logic [4:0]  rs,
                                  input logic [4:0]  rt,
                                  input logic [4:0]  rd,
                                  input logic [15:0] imm,
                                  input logic [25:0] target);
    enc_t r;
    r.word  = 32'd0;
    r.legal = 1'b1;
    case (mnem_e'(mnem))
      MN_AND:  r.word = {OP_AND,  rs, rt, rd, 11'd0};
      MN_NOR:  r.word = {OP_NOR,  rs, rt, rd, 11'd0};
      // NOT is a single-source R-type: rt slot is always zero
      MN_NOT:  r.word = {OP_NOT,  rs, 5'd0, rd, 11'd0};
      MN_ROLV: r.word = {OP_ROLV, rs, rt, rd, 11'd0};
      MN_RORV: r.word = {OP_RORV, rs, rt, rd, 11'd0};
      MN_LW:   r.word = {OP_LW,   rs, rt, imm};
      MN_SW:   r.word = {OP_SW,   rs, rt, imm};
      MN_NORI: r.word = {OP_NORI, rs, rt, imm};
      MN_BLEU: r.word = {OP_BLEU, rs, rt, imm};
      MN_JR:   r.word = {OP_JR,   rs, 21'd0};
      MN_JAL:  r.word = {OP_JAL,  target};
      default: begin
        r.word  = 32'd0;
        r.legal = 1'b0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry skid FIFO with valid/ready on both sides and a synchronous flush.
// The head entry is a register driven straight to out_data, so the output is
// stable while out_valid is held without out_ready.
// Ports: clk, rst_n (async active-low), flush (sync clear),
//        in_valid/in_ready/in_data (write side),
//        out_valid/out_ready/out_data (read side).
module skid_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;
  logic [1:0]       cnt_r;
  logic             push_s;
  logic             pop_s;

  assign in_ready  = (cnt_r != 2'd2);
  assign out_valid = (cnt_r != 2'd0);
  assign out_data  = head_r;
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // Occupancy counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 2'd0;
    end else if (flush) begin
      cnt_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Entry storage: head is always the oldest word; tail only used when full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r <= '0;
      tail_r <= '0;
    end else if (!flush) begin
      if (pop_s) begin
        if (cnt_r == 2'd2) begin
          head_r <= tail_r;
        end else if (push_s) begin
          head_r <= in_data;
        end else begin
          head_r <= head_r;
        end
      end else if (push_s) begin
        if (cnt_r == 2'd0) begin
          head_r <= in_data;
        end else begin
          tail_r <= in_data;
        end
      end else begin
        head_r <= head_r;
      end
    end else begin
      head_r <= head_r;
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts symbolic instructions on a valid/ready
// stream, encodes them into control-decoder words and writes them to
// instruction memory at auto-incrementing word addresses.
// Ports: clk, rst_n (async active-low), start (restart pulse),
//        in_valid/in_ready + in_mnem/in_rs/in_rt/in_rd/in_imm/in_target/in_last,
//        mem_we/mem_ready/mem_addr/mem_wdata (memory write handshake),
//        busy, done, err_illegal, err_overflow (status).
module instr_encoder_loader
  import instr_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_overflow
);

  localparam int FW = ADDR_W + 32;
  // One extra bit so a full program of 2**ADDR_W words is seen without wrap
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  load_state_e       state_r;
  load_state_e       state_n;
  logic [ADDR_W:0]   count_r;
  logic              err_illegal_r;
  logic              err_overflow_r;
  enc_t              enc_s;
  logic              xfer_s;
  logic              full_prog_s;
  logic              push_s;
  logic              fifo_in_ready_s;
  logic              fifo_out_valid_s;
  logic [FW-1:0]     fifo_in_data_s;
  logic [FW-1:0]     fifo_out_data_s;

  assign enc_s       = encode(in_mnem, in_rs, in_rt, in_rd, in_imm, in_target);
  assign full_prog_s = (count_r == DEPTH_C);
  // start blocks acceptance in its own cycle so it cleanly wins
  assign in_ready    = (state_r == ST_LOAD) & fifo_in_ready_s & ~err_overflow_r & ~start;
  assign xfer_s      = in_valid & in_ready;
  assign push_s      = xfer_s & enc_s.legal & ~full_prog_s;
  assign fifo_in_data_s = {BASE_C + count_r[ADDR_W-1:0], enc_s.word};

  skid_fifo2 #(.WIDTH(FW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (start),
    .in_valid  (push_s),
    .in_ready  (fifo_in_ready_s),
    .in_data   (fifo_in_data_s),
    .out_valid (fifo_out_valid_s),
    .out_ready (mem_ready),
    .out_data  (fifo_out_data_s)
  );

  assign mem_we       = fifo_out_valid_s;
  assign mem_addr     = fifo_out_valid_s ? fifo_out_data_s[FW-1:32] : BASE_C;
  assign mem_wdata    = fifo_out_valid_s ? fifo_out_data_s[31:0]    : 32'd0;
  assign busy         = (state_r == ST_LOAD) | (state_r == ST_DRAIN);
  assign done         = (state_r == ST_DONE);
  assign err_illegal  = err_illegal_r;
  assign err_overflow = err_overflow_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // FSM next-state logic; start restarts the load from any state
  always_comb begin
    state_n = state_r;
    if (start) begin
      state_n = ST_LOAD;
    end else begin
      case (state_r)
        ST_IDLE:  state_n = ST_IDLE;
        ST_LOAD: begin
          if (xfer_s && in_last) begin
            state_n = ST_DRAIN;
          end else begin
            state_n = ST_LOAD;
          end
        end
        ST_DRAIN: begin
          if (!fifo_out_valid_s) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_DRAIN;
          end
        end
        ST_DONE:  state_n = ST_DONE;
        default:  state_n = ST_IDLE;
      endcase
    end
  end

  // Count of words enqueued since start; also sources each entry's address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (start) begin
      count_r <= '0;
    end else if (push_s) begin
      count_r <= count_r + (ADDR_W + 1)'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Sticky error flags, cleared only by start or reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal_r  <= 1'b0;
      err_overflow_r <= 1'b0;
    end else if (start) begin
      err_illegal_r  <= 1'b0;
      err_overflow_r <= 1'b0;
    end else begin
      if (xfer_s && !enc_s.legal) begin
        err_illegal_r <= 1'b1;
      end
      if (xfer_s && full_prog_s) begin
        err_overflow_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_mnem;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          in_last;
  logic          mem_we;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          err_illegal;
  logic          err_overflow;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(AW), .DEPTH(4), .BASE_ADDR(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mnem      (in_mnem),
    .in_rs        (in_rs),
    .in_rt        (in_rt),
    .in_rd        (in_rd),
    .in_imm       (in_imm),
    .in_target    (in_target),
    .in_last      (in_last),
    .mem_we       (mem_we),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .err_illegal  (err_illegal),
    .err_overflow (err_overflow)
  );

  typedef struct {
    logic [3:0]  mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  vec_t          tbl[13];
  wr_t           exp_q[$];
  wr_t           mon_e;
  logic [AW-1:0] next_addr;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Write monitor: pops the scoreboard on each write, checks hold while stalled
  logic          stall_prev = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [31:0]   prev_data;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_we", {31'd0, mem_we}, 32'd1);
        chk("hold_addr", {30'd0, mem_addr}, {30'd0, prev_addr});
        chk("hold_data", mem_wdata, prev_data);
      end
      if (mem_we && mem_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write", mem_addr, mem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", {30'd0, mem_addr}, {30'd0, mon_e.addr});
          chk("wr_data", mem_wdata, mon_e.data);
        end
      end
      stall_prev = mem_we && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
    end
  end

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    next_addr = '0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive(input vec_t v, input logic last, input logic expw);
    wr_t e;
    @(posedge clk); #1;
    in_mnem   = v.mnem;
    in_rs     = v.rs;
    in_rt     = v.rt;
    in_rd     = v.rd;
    in_imm    = v.imm;
    in_target = v.target;
    in_last   = last;
    in_valid  = 1'b1;
    if (expw) begin
      e.addr = next_addr;
      e.data = v.word;
      exp_q.push_back(e);
      next_addr = next_addr + 2'd1;
    end
  endtask

  task automatic wait_accept();
    int k;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      if (in_ready) break;
      k++;
    end
    if (k >= 40) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 40 cycles, expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send(input vec_t v, input logic last, input logic expw);
    drive(v, last, expw);
    wait_accept();
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (k < 40 && !done) begin
      @(negedge clk);
      k++;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // mnem, rs, rt, rd, imm, target, legal, expected word
    tbl[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  16'hABCD, 26'h1555555, 1'b1, 32'h80221800}; // AND
    tbl[1]  = '{4'd1,  5'd4,  5'd5,  5'd31, 16'h0010, 26'h0000000, 1'b1, 32'h8C850010}; // LW
    tbl[2]  = '{4'd2,  5'd31, 5'd0,  5'd7,  16'hFFFF, 26'h0000000, 1'b1, 32'hAFE0FFFF}; // SW
    tbl[3]  = '{4'd3,  5'd9,  5'd3,  5'd4,  16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h21200000}; // JR
    tbl[4]  = '{4'd4,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000040, 1'b1, 32'h0C000040}; // JAL
    tbl[5]  = '{4'd5,  5'd10, 5'd11, 5'd12, 16'h0000, 26'h0000000, 1'b1, 32'h994B6000}; // NOR
    tbl[6]  = '{4'd6,  5'd1,  5'd2,  5'd0,  16'h1234, 26'h0000000, 1'b1, 32'h38221234}; // NORI
    tbl[7]  = '{4'd7,  5'd6,  5'd9,  5'd7,  16'h0000, 26'h0000000, 1'b1, 32'h10C03800}; // NOT
    tbl[8]  = '{4'd8,  5'd3,  5'd4,  5'd0,  16'h8000, 26'h0000000, 1'b1, 32'h40648000}; // BLEU
    tbl[9]  = '{4'd9,  5'd2,  5'd3,  5'd4,  16'h0000, 26'h0000000, 1'b1, 32'h00432000}; // ROLV
    tbl[10] = '{4'd10, 5'd5,  5'd6,  5'd7,  16'h0000, 26'h0000000, 1'b1, 32'h08A63800}; // RORV
    tbl[11] = '{4'd11, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0000000, 1'b0, 32'h00000000}; // illegal
    tbl[12] = '{4'd15, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0000000, 1'b0, 32'h00000000}; // illegal

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b1;
    in_mnem = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 16'd0; in_target = 26'd0;
    next_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_errs", {30'd0, err_illegal, err_overflow}, 32'd0);
    chk("rst_mem_addr", {30'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);

    // Single AND program: latency and done timing
    do_start();
    send(tbl[0], 1'b1, 1'b1);
    @(negedge clk);
    chk("t1_we_next_cycle", {31'd0, mem_we}, 32'd1);
    @(negedge clk);
    chk("t1_done_early", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_q_empty", exp_q.size(), 32'd0);

    // Table: each mnemonic as its own one-instruction program
    for (int i = 0; i < 13; i++) begin
      do_start();
      send(tbl[i], 1'b1, tbl[i].legal);
      wait_done("tbl_done");
      chk("tbl_err_illegal", {31'd0, err_illegal}, {31'd0, ~tbl[i].legal});
      chk("tbl_q_empty", exp_q.size(), 32'd0);
    end

    // Stream LW, JAL, NOT
    do_start();
    send(tbl[1], 1'b0, 1'b1);
    send(tbl[4], 1'b0, 1'b1);
    send(tbl[7], 1'b1, 1'b1);
    wait_done("stream_done");
    chk("stream_q_empty", exp_q.size(), 32'd0);

    // Memory stall with two words buffered
    do_start();
    mem_ready = 1'b0;
    send(tbl[5], 1'b0, 1'b1);
    send(tbl[6], 1'b0, 1'b1);
    drive(tbl[8], 1'b0, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    wait_accept();
    send(tbl[9], 1'b1, 1'b1);
    wait_done("stall_done");
    chk("stall_q_empty", exp_q.size(), 32'd0);

    // Illegal mnemonic between two legal ones
    do_start();
    send(tbl[0], 1'b0, 1'b1);
    send(tbl[11], 1'b0, 1'b0);
    send(tbl[1], 1'b1, 1'b1);
    wait_done("ill_done");
    repeat (3) @(negedge clk);
    chk("ill_sticky", {31'd0, err_illegal}, 32'd1);
    chk("ill_no_ovf", {31'd0, err_overflow}, 32'd0);
    chk("ill_q_empty", exp_q.size(), 32'd0);

    // Overflow: five instructions into a four-word program
    do_start();
    for (int i = 0; i < 4; i++) send(tbl[i], 1'b0, 1'b1);
    send(tbl[5], 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("ovf_err", {31'd0, err_overflow}, 32'd1);
    chk("ovf_in_ready", {31'd0, in_ready}, 32'd0);
    chk("ovf_q_empty", exp_q.size(), 32'd0);
    do_start();
    @(negedge clk);
    chk("ovf_cleared", {31'd0, err_overflow}, 32'd0);
    chk("ovf_ready_again", {31'd0, in_ready}, 32'd1);
    send(tbl[2], 1'b1, 1'b1);
    wait_done("ovf_restart_done");
    chk("ovf_restart_q_empty", exp_q.size(), 32'd0);

    // start and input in the same cycle: start wins
    do_start();
    @(posedge clk); #1;
    start = 1'b1;
    in_mnem = tbl[0].mnem; in_rs = tbl[0].rs; in_rt = tbl[0].rt; in_rd = tbl[0].rd;
    in_valid = 1'b1;
    @(negedge clk);
    chk("start_blocks_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("start_no_write", {31'd0, mem_we}, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd1);

    // Reset in DRAIN with two words buffered
    do_start();
    mem_ready = 1'b0;
    send(tbl[3], 1'b0, 1'b1);
    send(tbl[4], 1'b1, 1'b1);
    @(negedge clk);
    chk("drain_busy", {31'd0, busy}, 32'd1);
    chk("drain_we", {31'd0, mem_we}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_drain_we", {31'd0, mem_we}, 32'd0);
    chk("rst_drain_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_we", {31'd0, mem_we}, 32'd0);
    chk("post_rst_idle", {30'd0, busy, done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
